// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: shares one ALU among NUM_REQ requesters. One operation is in
// flight at a time: grant, drive the ALU for the command-dependent latency,
// capture result and flags, then hold a tagged response until it is accepted.
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration; without it the
// lowest-index valid requester always wins and no pointer register exists.
module alu_op_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int OPERAND_WIDTH = 8,
  parameter int CMD_WIDTH     = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_mode,
  input  logic [NUM_REQ-1:0]               req_cin,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]     req_cmd,
  input  logic [2*NUM_REQ-1:0]             req_inp_valid,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_opa,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_opb,
  output logic                             alu_ce,
  output logic                             alu_mode,
  output logic                             alu_cin,
  output logic [CMD_WIDTH-1:0]             alu_cmd,
  output logic [1:0]                       alu_inp_valid,
  output logic [OPERAND_WIDTH-1:0]         alu_opa,
  output logic [OPERAND_WIDTH-1:0]         alu_opb,
  input  logic [2*OPERAND_WIDTH-1:0]       alu_res,
  input  logic                             alu_err,
  input  logic                             alu_oflow,
  input  logic                             alu_cout,
  input  logic                             alu_e,
  input  logic                             alu_g,
  input  logic                             alu_l,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [2*OPERAND_WIDTH-1:0]       rsp_res,
  output logic [5:0]                       rsp_flags
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_EXEC, S_CAPT, S_RESP} state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     w_any_valid;
  logic [ID_W-1:0]          w_grant_id;
  logic                     w_grant;
  logic                     w_is_mul;
  logic                     w_drive;
  logic                     r_exec_cnt;

  logic [ID_W-1:0]          r_op_id;
  logic                     r_op_mode;
  logic                     r_op_cin;
  logic [CMD_WIDTH-1:0]     r_op_cmd;
  logic [1:0]               r_op_iv;
  logic [OPERAND_WIDTH-1:0] r_op_opa;
  logic [OPERAND_WIDTH-1:0] r_op_opb;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] r_rr_ptr;
  int              w_rr_idx;

  // Round-robin search beginning at the pointer, wrapping modulo NUM_REQ.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_any_valid = 1'b0;
    w_grant_id  = '0;
    w_rr_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rr_idx = int'(r_rr_ptr) + k;
      if (w_rr_idx >= NUM_REQ) w_rr_idx = w_rr_idx - NUM_REQ;
      if (!w_any_valid && req_valid[ID_W'(w_rr_idx)]) begin
        w_any_valid = 1'b1;
        w_grant_id  = ID_W'(w_rr_idx);
      end
    end
  end

  // Pointer moves to the requester after the winner, only when a grant is made.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_rr_ptr <= '0;
    else if (w_grant) r_rr_ptr <= (int'(w_grant_id) == NUM_REQ - 1) ? '0 : w_grant_id + 1'b1;
  end
`else
  // Fixed priority: scanning downward leaves the lowest-index valid requester.
  always_comb begin
    w_any_valid = 1'b0;
    w_grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_any_valid = 1'b1;
        w_grant_id  = ID_W'(k);
      end
    end
  end
`endif

  assign w_grant  = (r_state == S_IDLE) && w_any_valid;
  assign w_is_mul = r_op_mode && ((r_op_cmd == CMD_WIDTH'(9)) || (r_op_cmd == CMD_WIDTH'(10)));
  assign w_drive  = (r_state == S_ISSUE) || (r_state == S_EXEC) || (r_state == S_CAPT);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop updates from pre-edge values; RST clears asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_EXEC;
      S_EXEC:  if (r_exec_cnt == 1'b0) w_next_state = S_CAPT;
      S_CAPT:  w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Op register: the granted requester's fields are sampled only in the grant cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op_id   <= '0;
      r_op_mode <= 1'b0;
      r_op_cin  <= 1'b0;
      r_op_cmd  <= '0;
      r_op_iv   <= '0;
      r_op_opa  <= '0;
      r_op_opb  <= '0;
    end else if (w_grant) begin
      r_op_id   <= w_grant_id;
      r_op_mode <= req_mode[w_grant_id];
      r_op_cin  <= req_cin[w_grant_id];
      r_op_cmd  <= req_cmd[w_grant_id*CMD_WIDTH +: CMD_WIDTH];
      r_op_iv   <= req_inp_valid[w_grant_id*2 +: 2];
      r_op_opa  <= req_opa[w_grant_id*OPERAND_WIDTH +: OPERAND_WIDTH];
      r_op_opb  <= req_opb[w_grant_id*OPERAND_WIDTH +: OPERAND_WIDTH];
    end
  end

  // Exec counter: one EXEC cycle for normal ops, two for multiplies.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                        r_exec_cnt <= 1'b0;
    else if (r_state == S_ISSUE)                    r_exec_cnt <= w_is_mul;
    else if (r_state == S_EXEC && r_exec_cnt != 0)  r_exec_cnt <= r_exec_cnt - 1'b1;
  end

  // Response registers: loaded in CAPT, held through RESP until accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_id    <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else if (r_state == S_CAPT) begin
      rsp_id    <= r_op_id;
      rsp_res   <= alu_res;
      rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
    end
  end

  // ALU pins driven from the op register only while the op is being executed.
  always_comb begin
    alu_ce        = w_drive;
    alu_mode      = 1'b0;
    alu_cin       = 1'b0;
    alu_cmd       = '0;
    alu_inp_valid = '0;
    alu_opa       = '0;
    alu_opb       = '0;
    if (w_drive) begin
      alu_mode      = r_op_mode;
      alu_cin       = r_op_cin;
      alu_cmd       = r_op_cmd;
      alu_inp_valid = r_op_iv;
      alu_opa       = r_op_opa;
      alu_opb       = r_op_opb;
    end
  end

  // One-hot accept pulse in the grant cycle; suppressed while reset is held.
  always_comb begin
    req_ready = '0;
    if (w_grant && !RST) req_ready[w_grant_id] = 1'b1;
  end

  assign rsp_valid = (r_state == S_RESP);

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: behavioural ALU model on the alu_* pins, a table of
// directed single operations, hand-written contention / backpressure / reset
// sequences, and a randomized run checked cycle by cycle against a
// transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_alu_op_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int C   = 4;
  localparam int IDW = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_mode = '0;
  logic [N-1:0]   req_cin = '0;
  logic [N*C-1:0] req_cmd = '0;
  logic [2*N-1:0] req_inp_valid = '0;
  logic [N*W-1:0] req_opa = '0;
  logic [N*W-1:0] req_opb = '0;
  logic           alu_ce, alu_mode, alu_cin;
  logic [C-1:0]   alu_cmd;
  logic [1:0]     alu_inp_valid;
  logic [W-1:0]   alu_opa, alu_opb;
  logic [2*W-1:0] alu_res;
  logic           alu_err, alu_oflow, alu_cout, alu_e, alu_g, alu_l;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_res;
  logic [5:0]     rsp_flags;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_op_arbiter #(.NUM_REQ(N), .OPERAND_WIDTH(W), .CMD_WIDTH(C)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cin(req_cin),
    .req_cmd(req_cmd), .req_inp_valid(req_inp_valid), .req_opa(req_opa), .req_opb(req_opb),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
    .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .alu_e(alu_e), .alu_g(alu_g), .alu_l(alu_l),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  typedef struct packed { logic [2*W-1:0] res; logic [5:0] flags; } alu_out_t;
  typedef struct { int id; logic mode; logic [C-1:0] cmd; logic [1:0] iv; logic [W-1:0] a; logic [W-1:0] b; logic cin; } op_t;
  typedef struct { op_t op; logic [2*W-1:0] res; logic [5:0] flags; int lat; } vec_t;

  // Behavioural ALU; flags packed {ERR, OFLOW, COUT, G, L, E}.
  function automatic alu_out_t alu_f(input logic m, input logic [C-1:0] c, input logic [1:0] iv,
                                     input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    alu_out_t o;
    logic both;
    o = '0;
    both = (iv == 2'b11);
    if (m) begin
      case (c)
        4'd0:  if (both) begin o.res = 16'(a) + 16'(b); o.flags[3] = o.res[8]; end else o.flags[5] = 1'b1;
        4'd1:  if (both) begin o.res = {{W{1'b0}}, W'(a - b)}; o.flags[4] = (a < b); end else o.flags[5] = 1'b1;
        4'd2:  if (both) begin o.res = 16'(a) + 16'(b) + 16'(ci); o.flags[3] = o.res[8]; end else o.flags[5] = 1'b1;
        4'd4:  if (iv[0]) begin o.res = 16'(a) + 16'd1; o.flags[3] = o.res[8]; end else o.flags[5] = 1'b1;
        4'd8:  if (both) begin o.flags[2] = (a > b); o.flags[1] = (a < b); o.flags[0] = (a == b); end
               else o.flags[5] = 1'b1;
        4'd9:  if (both) o.res = (16'(a) + 16'd1) * (16'(b) + 16'd1); else o.flags[5] = 1'b1;
        4'd10: if (both) o.res = (16'(a) << 1) * 16'(b); else o.flags[5] = 1'b1;
        default: o.flags[5] = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0:  if (both) o.res = {{W{1'b0}}, a & b}; else o.flags[5] = 1'b1;
        4'd1:  if (both) o.res = {{W{1'b0}}, a | b}; else o.flags[5] = 1'b1;
        4'd2:  if (both) o.res = {{W{1'b0}}, a ^ b}; else o.flags[5] = 1'b1;
        default: o.flags[5] = 1'b1;
      endcase
    end
    return o;
  endfunction

  alu_out_t w_alu;
  assign w_alu   = alu_f(alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb, alu_cin);
  assign alu_res = w_alu.res;
  assign {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} = w_alu.flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pins();
    return 32'({alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb});
  endfunction

  function automatic logic [31:0] exp_pins(input op_t o, input logic ce);
    if (!ce) return 32'd0;
    return 32'({1'b1, o.mode, o.cin, o.cmd, o.iv, o.a, o.b});
  endfunction

  function automatic int lat_of(input op_t o);
    return (o.mode && (o.cmd == 4'd9 || o.cmd == 4'd10)) ? 5 : 4;
  endfunction

  // Which requester wins, from the valid set and the next-search-start pointer.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef ALU_ARB_RR_EN
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic set_req(input op_t o);
    req_mode[o.id]            = o.mode;
    req_cin[o.id]             = o.cin;
    req_cmd[o.id*C +: C]      = o.cmd;
    req_inp_valid[o.id*2 +: 2] = o.iv;
    req_opa[o.id*W +: W]      = o.a;
    req_opb[o.id*W +: W]      = o.b;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Entered at a drive point with requests applied; returns sampled in the grant cycle.
  task automatic wait_grant(input string name, input int exp_id);
    for (int t = 0; t < 8; t++) begin
      #2;
      if (req_ready != '0) break;
      @(negedge CLK);
    end
    check(name, 32'(req_ready), 32'(1 << exp_id));
  endtask

  // Entered at the drive point of G+1; returns sampled in the first rsp_valid cycle.
  task automatic await_rsp(input op_t o, output int lat);
    lat = 0;
    for (int t = 1; t <= 10; t++) begin
      #2;
      if (t == 1) check("issue_pins", pins(), exp_pins(o, 1'b1));
      if (rsp_valid) begin lat = t; break; end
      @(negedge CLK);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge CLK);
    set_req(v.op);
    req_valid = '0;
    req_valid[v.op.id] = 1'b1;
    rsp_ready = 1'b1;
    wait_grant("vec_grant", v.op.id);
    @(negedge CLK);
    req_valid = '0;
    await_rsp(v.op, lat);
    check("vec_latency", 32'(lat), 32'(v.lat));
    check("vec_id", 32'(rsp_id), 32'(v.op.id));
    check("vec_res", 32'(rsp_res), 32'(v.res));
    check("vec_flags", 32'(rsp_flags), 32'(v.flags));
  endtask

  function automatic op_t rand_op(input int id);
    op_t o;
    int sel;
    o.id   = id;
    o.mode = 1'($urandom_range(0, 1));
    sel    = $urandom_range(0, 9);
    case (sel)
      0: o.cmd = 4'd0;  1: o.cmd = 4'd1;  2: o.cmd = 4'd2;  3: o.cmd = 4'd4;
      4: o.cmd = 4'd8;  5, 7: o.cmd = 4'd9;  6, 8: o.cmd = 4'd10;
      default: o.cmd = 4'($urandom_range(0, 15));
    endcase
    o.iv  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
    o.a   = 8'($urandom_range(0, 255));
    o.b   = 8'($urandom_range(0, 255));
    o.cin = 1'($urandom_range(0, 1));
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    op_t  o, o1, o3, fl;
    op_t  cur[N];
    int   exp_order[5];
    int   lat, ng, prev, ptr, cyc, w, last_w;
    bit   busy, exp_rv;
    alu_out_t ex;

    vecs[0] = '{'{0, 1'b1, 4'd0,  2'b11, 8'hFF, 8'h01, 1'b0}, 16'h0100, 6'b001000, 4};
    vecs[1] = '{'{2, 1'b1, 4'd9,  2'b11, 8'h03, 8'h04, 1'b0}, 16'h0014, 6'b000000, 5};
    vecs[2] = '{'{1, 1'b1, 4'd4,  2'b10, 8'h33, 8'h44, 1'b0}, 16'h0000, 6'b100000, 4};
    vecs[3] = '{'{3, 1'b1, 4'd8,  2'b11, 8'h05, 8'h07, 1'b0}, 16'h0000, 6'b000010, 4};
    vecs[4] = '{'{1, 1'b1, 4'd1,  2'b11, 8'h03, 8'h05, 1'b0}, 16'h00FE, 6'b010000, 4};
    vecs[5] = '{'{3, 1'b0, 4'd2,  2'b11, 8'hF0, 8'h3C, 1'b0}, 16'h00CC, 6'b000000, 4};
    vecs[6] = '{'{2, 1'b1, 4'd10, 2'b11, 8'h03, 8'h05, 1'b0}, 16'h001E, 6'b000000, 5};
    vecs[7] = '{'{0, 1'b1, 4'd2,  2'b11, 8'h10, 8'h20, 1'b1}, 16'h0031, 6'b000000, 4};
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif

    // Reset state, with every requester asking during reset.
    #1 RST = 1'b1;
    for (int i = 0; i < N; i++) set_req(vecs[i % 8].op);
    req_valid = '1;
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_res", 32'(rsp_res), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_alu_pins", pins(), 32'd0);
    req_valid = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Directed single operations.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention: all requesters hold valid, response always accepted.
    do_reset();
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      o = '{i, 1'b1, 4'd0, 2'b11, 8'(i), 8'h10, 1'b0};
      set_req(o);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    ng = 0;
    prev = 0;
    for (int t = 0; t < 40 && ng < 5; t++) begin
      #2;
      if (req_ready != '0) begin
        check("cont_grant", 32'(req_ready), 32'(1 << exp_order[ng]));
        if (ng > 0) check("cont_spacing", 32'(t - prev), 32'd5);
        prev = t;
        ng++;
      end
      @(negedge CLK);
    end
    check("cont_count", 32'(ng), 32'd5);
    req_valid = '0;

    // Backpressure: response held 10 cycles while another requester waits.
    do_reset();
    @(negedge CLK);
    set_req(vecs[0].op);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    wait_grant("bp_grant", 0);
    @(negedge CLK);
    req_valid = '0;
    await_rsp(vecs[0].op, lat);
    check("bp_latency", 32'(lat), 32'd4);
    o1 = '{1, 1'b1, 4'd1, 2'b11, 8'h40, 8'h01, 1'b0};
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      if (t == 0) begin set_req(o1); req_valid[1] = 1'b1; end
      #2;
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_res", 32'(rsp_res), 32'(vecs[0].res));
      check("bp_hold_flags", 32'(rsp_flags), 32'(vecs[0].flags));
      check("bp_alu_idle", pins(), 32'd0);
      check("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(negedge CLK);
    rsp_ready = 1'b1;
    #2;
    check("bp_xfer_valid", 32'(rsp_valid), 32'd1);
    check("bp_xfer_no_grant", 32'(req_ready), 32'd0);
    @(negedge CLK);
    #2;
    check("bp_next_grant", 32'(req_ready), 32'b0010);
    check("bp_next_idle", 32'(rsp_valid), 32'd0);

    // Reset during EXEC of a multiply.
    do_reset();
    @(negedge CLK);
    set_req(vecs[1].op);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    wait_grant("mr_grant", 2);
    @(negedge CLK);
    req_valid = '0;
    @(negedge CLK);
    #2;
    check("mr_exec_ce", 32'(alu_ce), 32'd1);
    RST = 1'b1;
    #1;
    check("mr_ce_async", 32'(alu_ce), 32'd0);
    check("mr_pins_async", pins(), 32'd0);
    check("mr_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      #2;
      check("mr_discarded", 32'(rsp_valid), 32'd0);
    end
    @(negedge CLK);
    o1 = '{1, 1'b1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b0};
    o3 = '{3, 1'b1, 4'd9, 2'b11, 8'h01, 8'h01, 1'b0};
    set_req(o1);
    set_req(o3);
    req_valid = 4'b1010;
    #2;
    check("mr_regrant", 32'(req_ready), 32'b0010);
    @(negedge CLK);
    req_valid = '0;
    await_rsp(o1, lat);
    check("mr_latency", 32'(lat), 32'd4);
    check("mr_id", 32'(rsp_id), 32'd1);
    check("mr_res", 32'(rsp_res), 32'h0046);

    // Randomized traffic against a transaction-level model.
    do_reset();
    ptr = 0; busy = 0; cyc = 0; last_w = -1; lat = 4;
    fl = '{0, 1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0};
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        if (i == last_w) req_valid[i] = 1'b0;
        else if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          cur[i] = rand_op(i);
          set_req(cur[i]);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      last_w = -1;
      #2;
      if (busy) cyc++;
      exp_rv = busy && (cyc >= lat);
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("rnd_alu_pins", pins(), exp_pins(fl, busy && cyc >= 1 && cyc < lat));
      if (exp_rv) begin
        ex = alu_f(fl.mode, fl.cmd, fl.iv, fl.a, fl.b, fl.cin);
        check("rnd_rsp_id", 32'(rsp_id), 32'(fl.id));
        check("rnd_rsp_res", 32'(rsp_res), 32'(ex.res));
        check("rnd_rsp_flags", 32'(rsp_flags), 32'(ex.flags));
      end
      w = busy ? -1 : pick(req_valid, ptr);
      check("rnd_req_ready", 32'(req_ready), (w >= 0) ? 32'(1 << w) : 32'd0);
      if (w >= 0) begin
        busy = 1; cyc = 0; fl = cur[w]; lat = lat_of(fl);
        ptr = (w + 1) % N;
        last_w = w;
      end else if (exp_rv && rsp_ready) begin
        busy = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
